// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe: pipelined popcount with leaf counters, registered adder tree and global stall
module bit_population_counter_pipe #(
    parameter int WIDTH  = 16,
    parameter int LEAF_W = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   mode_i,
    input  logic                   data_val_i,
    output logic                   data_ready_o,
    output logic [$clog2(WIDTH):0] data_o,
    output logic                   data_val_o,
    input  logic                   data_ready_i
);
    localparam int NLEAF = (WIDTH + LEAF_W - 1) / LEAF_W;
    localparam int LVL   = $clog2(NLEAF);
    localparam int OW    = $clog2(WIDTH) + 1;
    localparam int CW    = $clog2(LEAF_W) + 1 + LVL;

    logic [NLEAF*LEAF_W-1:0] w_pad;
    logic [CW-1:0]           w_leaf [NLEAF];
    logic [CW-1:0]           r_sum  [LVL+1][2*NLEAF];
    logic [LVL:0]            r_val;
    logic                    w_en;

    assign w_en         = data_ready_i | ~r_val[LVL];
    assign data_ready_o = w_en;
    assign data_val_o   = r_val[LVL];
    assign data_o       = OW'(r_sum[LVL][0]);

    // invert only the real bits in count-zeros mode; pad bits of the last leaf stay zero
    always_comb begin
        w_pad = '0;
        w_pad[WIDTH-1:0] = data_i ^ {WIDTH{mode_i}};
        for (int i = 0; i < NLEAF; i++) begin
            w_leaf[i] = '0;
            for (int j = 0; j < LEAF_W; j++) w_leaf[i] = w_leaf[i] + CW'(w_pad[i*LEAF_W+j]);
        end
    end

    // every stage advances under one enable; entries beyond a level's width stay zero, so an odd element passes through as x+0
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_val <= '0;
            for (int l = 0; l <= LVL; l++)
                for (int i = 0; i < 2*NLEAF; i++) r_sum[l][i] <= '0;
        end else if (w_en) begin
            r_val[0] <= data_val_i;
            for (int i = 0; i < NLEAF; i++) r_sum[0][i] <= w_leaf[i];
            for (int l = 1; l <= LVL; l++) begin
                r_val[l] <= r_val[l-1];
                for (int i = 0; i < NLEAF; i++) r_sum[l][i] <= r_sum[l-1][2*i] + r_sum[l-1][2*i+1];
            end
        end
    end
endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// tb_bit_population_counter_pipe: directed and backpressure checks of the popcount pipe at several widths
module tb_bit_population_counter_pipe;
    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic [31:0] d = '0;
    logic        mode = 1'b0, val = 1'b0, rdy_i = 1'b1;
    int          sel = 0, w = 16;
    bit          bp = 0, stalled = 0;
    int          vectors = 0, errs = 0, popped = 0;
    int          q[$];
    logic [5:0]  held = '0;
    logic [4:0]  o16, o10;
    logic [0:0]  o1;
    logic [5:0]  o32;
    logic        v16, v10, v1, v32, r16, r10, r1, r32;
    logic        ov, ordy;
    logic [5:0]  od;

    always #5 clk = ~clk;

    bit_population_counter_pipe #(.WIDTH(16), .LEAF_W(4)) u16 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d[15:0]), .mode_i(mode),
        .data_val_i(val && sel == 0), .data_ready_o(r16), .data_o(o16),
        .data_val_o(v16), .data_ready_i(rdy_i || sel != 0));
    bit_population_counter_pipe #(.WIDTH(10), .LEAF_W(4)) u10 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d[9:0]), .mode_i(mode),
        .data_val_i(val && sel == 1), .data_ready_o(r10), .data_o(o10),
        .data_val_o(v10), .data_ready_i(rdy_i || sel != 1));
    bit_population_counter_pipe #(.WIDTH(1), .LEAF_W(1)) u1 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d[0:0]), .mode_i(mode),
        .data_val_i(val && sel == 2), .data_ready_o(r1), .data_o(o1),
        .data_val_o(v1), .data_ready_i(rdy_i || sel != 2));
    bit_population_counter_pipe #(.WIDTH(32), .LEAF_W(4)) u32 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d), .mode_i(mode),
        .data_val_i(val && sel == 3), .data_ready_o(r32), .data_o(o32),
        .data_val_o(v32), .data_ready_i(rdy_i || sel != 3));

    assign ov   = sel == 0 ? v16 : sel == 1 ? v10 : sel == 2 ? v1 : v32;
    assign ordy = sel == 0 ? r16 : sel == 1 ? r10 : sel == 2 ? r1 : r32;
    assign od   = sel == 0 ? 6'(o16) : sel == 1 ? 6'(o10) : sel == 2 ? 6'(o1) : o32;

    function automatic int model(logic [31:0] x, logic m);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        return $countones((m ? ~x : x) & mask);
    endfunction

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // scoreboard: push on accept, pop on retire, and hold-check every stalled output
    always @(negedge clk) begin
        if (!arst_n) stalled = 0;
        else begin
            if (stalled) begin
                chk("stall_val", int'(ov), 1);
                chk("stall_data", int'(od), int'(held));
            end
            if (ov && rdy_i) begin
                if (q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL spurious_out: got %0d, expected no output", od);
                end else chk("out_data", int'(od), q.pop_front());
                popped++;
            end
            stalled = ov && !rdy_i;
            held = od;
            if (val && ordy) q.push_back(model(d, mode));
        end
    end

    task automatic do_reset(int s);
        arst_n = 1'b0;
        #1;
        sel = s;
        w = s == 0 ? 16 : s == 1 ? 10 : s == 2 ? 1 : 32;
        chk("rst_val", int'(ov), 0);
        chk("rst_data", int'(od), 0);
        chk("rst_ready", int'(ordy), 1);
        q.delete();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic send(logic [31:0] x, logic m);
        bit acc = 0;
        d = x;
        mode = m;
        val = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = ordy;
            @(posedge clk);
            #1;
            if (bp) rdy_i = 1'($urandom_range(0, 1));
        end
        val = 1'b0;
        if (!acc) begin
            vectors++;
            errs++;
            $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || ov) && n < 300) begin
            @(posedge clk);
            #1;
            if (bp) rdy_i = 1'($urandom_range(0, 1));
            n++;
        end
        if (n == 300) begin
            vectors++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
        bp = 0;
        rdy_i = 1'b1;
    endtask

    task automatic single(logic [31:0] x, logic m, int expv, int dep, string nm);
        int lat = 0;
        send(x, m);
        while (!ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, dep - 1);
        chk({nm, "_data"}, int'(od), expv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        longint t0;
        int sels[3] = '{0, 1, 3};
        #2;
        do_reset(0);
        single(32'hF0F1, 1'b0, 9, 3, "f0f1_m0");
        single(32'hF0F1, 1'b1, 7, 3, "f0f1_m1");
        single(32'h0000, 1'b0, 0, 3, "zeros_m0");
        single(32'hFFFF, 1'b0, 16, 3, "ones_m0");
        single(32'h0000, 1'b1, 16, 3, "zeros_m1");
        do_reset(1);
        single(32'h000, 1'b1, 10, 3, "w10_zeros_m1");
        single(32'h3FF, 1'b0, 10, 3, "w10_3ff_m0");
        foreach (sels[k]) begin
            do_reset(sels[k]);
            bp = 1;
            p0 = popped;
            for (int i = 0; i < 8; i++) send($urandom, 1'($urandom_range(0, 1)));
            drain();
            chk("bp_words", popped - p0, 8);
        end
        do_reset(0);
        for (int i = 0; i < 3; i++) send(32'hFFFF, 1'b0);
        chk("pre_rst_val", int'(ov), 1);
        #2;
        do_reset(0);
        p0 = popped;
        send(32'h0001, 1'b0);
        send(32'h0003, 1'b0);
        drain();
        chk("post_rst_words", popped - p0, 2);
        do_reset(2);
        single(32'h1, 1'b0, 1, 1, "w1_m0");
        single(32'h1, 1'b1, 0, 1, "w1_m1");
        p0 = popped;
        t0 = $time;
        for (int i = 0; i < 6; i++) send(32'(i), 1'(i >> 1));
        chk("w1_thru_cycles", int'(($time - t0) / 10), 6);
        drain();
        chk("w1_thru_words", popped - p0, 6);
        do_reset(3);
        single(32'hFFFF_0001, 1'b0, 17, 4, "w32_m0");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
